// File: rtl/cpu_timer_multi_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_timer_multi_pkg
// Purpose : Shared definitions for the multi-channel CPU timer: register
//           offsets within a channel window, CTRL/STAT bit positions and the
//           default channel count.
// Ports   : none (package)
// Config  : TIMER_CASCADE_EN enables the CTRL cascade bit (see top level)
// Rev     : 1.0 - initial release
// ============================================================================
package cpu_timer_multi_pkg;

  localparam int DEFAULT_NUM_CH = 2;

  // Register offsets, selected by bus_addr[2:0]. Offsets 4..7 are reserved.
  typedef enum logic [2:0] {
    TMR_CTRL = 3'd0,
    TMR_CMP  = 3'd1,
    TMR_CNT  = 3'd2,
    TMR_STAT = 3'd3
  } tmr_reg_e;

  // CTRL bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_MASK    = 2;
  localparam int CTRL_CASCADE = 3;
  localparam int CTRL_PRE_LSB = 8;

  // STAT bit positions
  localparam int STAT_PENDING = 0;
  localparam int STAT_RUNNING = 1;

endpackage
`default_nettype wire

// File: rtl/cpu_timer_multi_channel.sv
`default_nettype none
// ============================================================================
// Module  : cpu_timer_multi_channel
// Purpose : One timer channel: prescaler, counter, compare, sticky pending
//           flag and periodic/one-shot mode.
// Ports   : clk, reset        - clock, asynchronous active-high reset
//           wr_*_i            - one-cycle write strobes for CTRL/CMP/CNT/STAT
//           wdata_i           - bus write data
//           prev_match_i      - compare match of the previous channel
//                               (cascade tick source)
//           match_o           - this channel's compare match (tick & cnt==cmp)
//           ctrl_o/cmp_o/cnt_o/stat_o - register read-back values
//           irq_o             - pending & irq_mask_en
// Config  : TIMER_CASCADE_EN adds the CTRL cascade bit
// Rev     : 1.0 - initial release
// ============================================================================
module cpu_timer_multi_channel
  import cpu_timer_multi_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int PRE_W    = 8,
  parameter bit HAS_PREV = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_ctrl_i,
  input  logic             wr_cmp_i,
  input  logic             wr_cnt_i,
  input  logic             wr_stat_i,
  input  logic [31:0]      wdata_i,
  input  logic             prev_match_i,
  output logic             match_o,
  output logic [31:0]      ctrl_o,
  output logic [CNT_W-1:0] cmp_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic [1:0]       stat_o,
  output logic             irq_o
);

  logic             en_q, en_d;
  logic             oneshot_q, oneshot_d;
  logic             mask_q, mask_d;
  logic             pending_q, pending_d;
  logic [PRE_W-1:0] prescale_q, prescale_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0] cmp_q, cmp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cascade;
  logic             presc_hit;
  logic             tick;

`ifdef TIMER_CASCADE_EN
  logic cascade_q, cascade_d;
  assign cascade = cascade_q;
`else
  assign cascade = 1'b0;
`endif

  // Parts of the write bus that a given register does not use.
  logic unused_inputs;
  assign unused_inputs = ^{wdata_i, prev_match_i, HAS_PREV};

  assign presc_hit = (pre_cnt_q == prescale_q);
  // A cascaded channel counts the previous channel's matches instead of
  // its own prescaler ticks.
  assign tick      = en_q & (cascade ? prev_match_i : presc_hit);
  assign match_o   = tick & (cnt_q == cmp_q);

  always_comb begin
    en_d       = en_q;
    oneshot_d  = oneshot_q;
    mask_d     = mask_q;
    pending_d  = pending_q;
    prescale_d = prescale_q;
    pre_cnt_d  = pre_cnt_q;
    cmp_d      = cmp_q;
    cnt_d      = cnt_q;
`ifdef TIMER_CASCADE_EN
    cascade_d  = cascade_q;
`endif

    if (en_q && !cascade) begin
      pre_cnt_d = presc_hit ? '0 : pre_cnt_q + 1'b1;
    end

    // Clear first so a same-cycle hardware set overrides it.
    if (wr_stat_i && wdata_i[STAT_PENDING]) begin
      pending_d = 1'b0;
    end

    if (tick) begin
      if (match_o) begin
        pending_d = 1'b1;
        cnt_d     = '0;
        if (oneshot_q) begin
          en_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Bus writes come last so they take priority over counter updates.
    if (wr_ctrl_i) begin
      en_d       = wdata_i[CTRL_EN];
      oneshot_d  = wdata_i[CTRL_ONESHOT];
      mask_d     = wdata_i[CTRL_MASK];
      prescale_d = wdata_i[CTRL_PRE_LSB +: PRE_W];
`ifdef TIMER_CASCADE_EN
      cascade_d  = HAS_PREV & wdata_i[CTRL_CASCADE];
`endif
      if (wdata_i[CTRL_EN] && !en_q) begin
        pre_cnt_d = '0;
      end
    end
    if (wr_cmp_i) begin
      cmp_d = wdata_i[CNT_W-1:0];
    end
    if (wr_cnt_i) begin
      cnt_d = wdata_i[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q       <= 1'b0;
      oneshot_q  <= 1'b0;
      mask_q     <= 1'b0;
      pending_q  <= 1'b0;
      prescale_q <= '0;
      pre_cnt_q  <= '0;
      cmp_q      <= '0;
      cnt_q      <= '0;
`ifdef TIMER_CASCADE_EN
      cascade_q  <= 1'b0;
`endif
    end else begin
      en_q       <= en_d;
      oneshot_q  <= oneshot_d;
      mask_q     <= mask_d;
      pending_q  <= pending_d;
      prescale_q <= prescale_d;
      pre_cnt_q  <= pre_cnt_d;
      cmp_q      <= cmp_d;
      cnt_q      <= cnt_d;
`ifdef TIMER_CASCADE_EN
      cascade_q  <= cascade_d;
`endif
    end
  end

  always_comb begin
    ctrl_o                            = '0;
    ctrl_o[CTRL_EN]                   = en_q;
    ctrl_o[CTRL_ONESHOT]              = oneshot_q;
    ctrl_o[CTRL_MASK]                 = mask_q;
    ctrl_o[CTRL_PRE_LSB +: PRE_W]     = prescale_q;
    ctrl_o[CTRL_CASCADE]              = cascade;
  end

  assign cmp_o  = cmp_q;
  assign cnt_o  = cnt_q;
  assign stat_o = {en_q, pending_q};
  assign irq_o  = pending_q & mask_q;

endmodule
`default_nettype wire

// File: rtl/cpu_timer_multi.sv
`default_nettype none
// ============================================================================
// Module  : cpu_timer_multi
// Purpose : Multi-channel CPU timer. Word-addressed register bus (single-cycle
//           write, registered read), per-channel compare/prescale/mode, sticky
//           pending flags, and a registered OR of unmasked interrupts.
// Ports   : clk, reset   - clock, asynchronous active-high reset
//           bus_we/re    - write / read strobes
//           bus_addr     - [5:3] channel, [2:0] register
//           bus_wdata    - write data
//           bus_rdata    - read data, valid one cycle after bus_re, held
//           ch_irq       - per-channel pending & mask
//           timer_int    - registered OR of ch_irq
// Config  : TIMER_CASCADE_EN - CTRL[3] lets channel i>0 count matches of
//           channel i-1; when undefined CTRL[3] reads 0
// Rev     : 1.0 - initial release
// ============================================================================
module cpu_timer_multi
  import cpu_timer_multi_pkg::*;
#(
  parameter int NUM_CH = DEFAULT_NUM_CH,
  parameter int CNT_W  = 32,
  parameter int PRE_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bus_we,
  input  logic              bus_re,
  input  logic [5:0]        bus_addr,
  input  logic [31:0]       bus_wdata,
  output logic [31:0]       bus_rdata,
  output logic [NUM_CH-1:0] ch_irq,
  output logic              timer_int
);

  logic [2:0]       ch_sel;
  logic [2:0]       reg_sel;
  logic [NUM_CH:0]  match_chain;   // [i] feeds channel i's cascade input
  logic [31:0]      rd_ctrl [NUM_CH];
  logic [CNT_W-1:0] rd_cmp  [NUM_CH];
  logic [CNT_W-1:0] rd_cnt  [NUM_CH];
  logic [1:0]       rd_stat [NUM_CH];
  logic [31:0]      rdata_q, rdata_d;
  logic             timer_int_q;
  logic             unused_chain;

  assign ch_sel         = bus_addr[5:3];
  assign reg_sel        = bus_addr[2:0];
  assign match_chain[0] = 1'b0;
  assign unused_chain   = match_chain[NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_sel;
    assign wr_sel = bus_we && (ch_sel == 3'(i));

    cpu_timer_multi_channel #(
      .CNT_W    (CNT_W),
      .PRE_W    (PRE_W),
      .HAS_PREV (i > 0)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .wr_ctrl_i    (wr_sel && (reg_sel == TMR_CTRL)),
      .wr_cmp_i     (wr_sel && (reg_sel == TMR_CMP)),
      .wr_cnt_i     (wr_sel && (reg_sel == TMR_CNT)),
      .wr_stat_i    (wr_sel && (reg_sel == TMR_STAT)),
      .wdata_i      (bus_wdata),
      .prev_match_i (match_chain[i]),
      .match_o      (match_chain[i+1]),
      .ctrl_o       (rd_ctrl[i]),
      .cmp_o        (rd_cmp[i]),
      .cnt_o        (rd_cnt[i]),
      .stat_o       (rd_stat[i]),
      .irq_o        (ch_irq[i])
    );
  end

  // Read mux: unimplemented channels and reserved offsets return 0.
  always_comb begin
    rdata_d = rdata_q;
    if (bus_re) begin
      rdata_d = '0;
      for (int k = 0; k < NUM_CH; k++) begin
        if (ch_sel == 3'(k)) begin
          case (reg_sel)
            TMR_CTRL: rdata_d = rd_ctrl[k];
            TMR_CMP:  rdata_d = 32'(rd_cmp[k]);
            TMR_CNT:  rdata_d = 32'(rd_cnt[k]);
            TMR_STAT: rdata_d = 32'(rd_stat[k]);
            default:  rdata_d = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q     <= '0;
      timer_int_q <= 1'b0;
    end else begin
      rdata_q     <= rdata_d;
      timer_int_q <= |ch_irq;
    end
  end

  assign bus_rdata = rdata_q;
  assign timer_int = timer_int_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_timer_multi.sv
`default_nettype none
// ============================================================================
// Module  : tb_cpu_timer_multi
// Purpose : Self-checking bench for cpu_timer_multi: a table of directed bus
//           vectors with hand-derived expectations, hand-written multi-cycle
//           sequences (one-shot, wrap, async reset, cascade), then random bus
//           traffic checked every cycle against a behavioural channel model.
// Config  : honours TIMER_CASCADE_EN
// Rev     : 1.0 - initial release
// ============================================================================
module tb_cpu_timer_multi;

  localparam int NUM_CH = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              bus_we, bus_re;
  logic [5:0]        bus_addr;
  logic [31:0]       bus_wdata;
  logic [31:0]       bus_rdata;
  logic [NUM_CH-1:0] ch_irq;
  logic              timer_int;

  always #5 clk = ~clk;

  cpu_timer_multi #(.NUM_CH(NUM_CH), .CNT_W(32), .PRE_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus_we    (bus_we),
    .bus_re    (bus_re),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .ch_irq    (ch_irq),
    .timer_int (timer_int)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- behavioural model ----------------
  bit          m_en[NUM_CH], m_os[NUM_CH], m_mask[NUM_CH], m_casc[NUM_CH], m_pend[NUM_CH];
  int unsigned m_psc[NUM_CH], m_pre[NUM_CH], m_cmp[NUM_CH], m_cnt[NUM_CH];
  logic [31:0] m_rd;
  bit          m_ti;

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_en[i] = 0; m_os[i] = 0; m_mask[i] = 0; m_casc[i] = 0; m_pend[i] = 0;
      m_psc[i] = 0; m_pre[i] = 0; m_cmp[i] = 0; m_cnt[i] = 0;
    end
    m_rd = '0;
    m_ti = 0;
  endtask

  function automatic logic [31:0] model_read(logic [5:0] a);
    int c, r;
    c = int'(a[5:3]);
    r = int'(a[2:0]);
    if (c >= NUM_CH) return 32'd0;
    case (r)
      0: return (m_psc[c] << 8) | (32'(m_casc[c]) << 3) | (32'(m_mask[c]) << 2)
              | (32'(m_os[c]) << 1) | 32'(m_en[c]);
      1: return m_cmp[c];
      2: return m_cnt[c];
      3: return (32'(m_en[c]) << 1) | 32'(m_pend[c]);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [NUM_CH-1:0] model_irq();
    logic [NUM_CH-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[i] = m_pend[i] & m_mask[i];
    return v;
  endfunction

  // Advances the model by one clock edge given the inputs seen at that edge.
  task automatic model_step(input bit we, input bit re, input logic [5:0] a, input logic [31:0] d);
    bit tick[NUM_CH];
    bit hit[NUM_CH];
    bit en_old, wsel, prev;
    int c, r;
    c = int'(a[5:3]);
    r = int'(a[2:0]);
    if (re) m_rd = model_read(a);
    m_ti = |model_irq();
    for (int i = 0; i < NUM_CH; i++) begin
      prev    = (i > 0) ? hit[i-1] : 1'b0;
      tick[i] = m_en[i] && (m_casc[i] ? prev : (m_pre[i] == m_psc[i]));
      hit[i]  = tick[i] && (m_cnt[i] == m_cmp[i]);
    end
    for (int i = 0; i < NUM_CH; i++) begin
      en_old = m_en[i];
      wsel   = we && (c == i);
      if (m_en[i] && !m_casc[i])
        m_pre[i] = (m_pre[i] == m_psc[i]) ? 0 : (m_pre[i] + 1) % 256;
      if (wsel && r == 3 && d[0]) m_pend[i] = 0;
      if (tick[i]) begin
        if (hit[i]) begin
          m_pend[i] = 1;
          m_cnt[i]  = 0;
          if (m_os[i]) m_en[i] = 0;
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
        end
      end
      if (wsel && r == 0) begin
        if (d[0] && !en_old) m_pre[i] = 0;
        m_en[i]   = d[0];
        m_os[i]   = d[1];
        m_mask[i] = d[2];
        m_psc[i]  = (d >> 8) & 32'hFF;
`ifdef TIMER_CASCADE_EN
        m_casc[i] = (i > 0) && d[3];
`else
        m_casc[i] = 0;
`endif
      end
      if (wsel && r == 1) m_cmp[i] = d;
      if (wsel && r == 2) m_cnt[i] = d;
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit we, input bit re, input logic [5:0] a, input logic [31:0] d);
    bus_we = we; bus_re = re; bus_addr = a; bus_wdata = d;
    @(posedge clk);
    model_step(we, re, a, d);
    #1;
    chk("model_rdata", bus_rdata, m_rd);
    chk("model_ch_irq", 32'(ch_irq), 32'(model_irq()));
    chk("model_timer_int", 32'(timer_int), 32'(m_ti));
    bus_we = 0; bus_re = 0;
  endtask

  task automatic idle();
    cycle(0, 0, 6'h00, 32'h0);
  endtask

  // Runs idle cycles until ch_irq[ch] is high; returns cycles taken
  // (limit+1 if it never rises).
  task automatic wait_irq(input int ch, input int limit, output int n);
    n = limit + 1;
    for (int k = 1; k <= limit; k++) begin
      idle();
      if (ch_irq[ch]) begin
        n = k;
        break;
      end
    end
  endtask

  typedef struct {
    bit          we;
    bit          re;
    logic [5:0]  a;
    logic [31:0] d;
    logic [31:0] e_rd;
    logic [1:0]  e_irq;
    bit          e_ti;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit we, bit re, logic [5:0] a, logic [31:0] d,
                              logic [31:0] e_rd, logic [1:0] e_irq, bit e_ti);
    vec_t v;
    v.we = we; v.re = re; v.a = a; v.d = d;
    v.e_rd = e_rd; v.e_irq = e_irq; v.e_ti = e_ti;
    tbl.push_back(v);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [31:0] d;
    int          ch, rg;
    logic [31:0] ctrl_rb;

    reset = 1; bus_we = 0; bus_re = 0; bus_addr = '0; bus_wdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_rdata", bus_rdata, 32'h0);
    chk("reset_ch_irq", 32'(ch_irq), 32'h0);
    chk("reset_timer_int", 32'(timer_int), 32'h0);
    reset = 0;

`ifdef TIMER_CASCADE_EN
    ctrl_rb = 32'h30E;
`else
    ctrl_rb = 32'h306;
`endif

    // Ch0 periodic, CMP=4, prescale 0, mask on: pending every 5 cycles.
    //   we re addr   wdata         rdata        irq  ti
    add(1, 0, 6'h01, 32'd4,        32'h0,       2'b00, 0);
    add(1, 0, 6'h00, 32'h5,        32'h0,       2'b00, 0);
    add(0, 1, 6'h02, 32'h0,        32'h0,       2'b00, 0);
    add(0, 1, 6'h02, 32'h0,        32'h1,       2'b00, 0);
    add(0, 0, 6'h00, 32'h0,        32'h1,       2'b00, 0);
    add(0, 1, 6'h03, 32'h0,        32'h2,       2'b00, 0);
    add(0, 0, 6'h00, 32'h0,        32'h2,       2'b01, 0);
    add(0, 1, 6'h03, 32'h0,        32'h3,       2'b01, 1);
    add(1, 0, 6'h03, 32'h1,        32'h3,       2'b00, 1);
    add(0, 0, 6'h00, 32'h0,        32'h3,       2'b00, 0);
    add(0, 0, 6'h00, 32'h0,        32'h3,       2'b00, 0);
    add(0, 0, 6'h00, 32'h0,        32'h3,       2'b01, 0);
    add(0, 1, 6'h02, 32'h0,        32'h0,       2'b01, 1);
    add(1, 0, 6'h03, 32'h1,        32'h0,       2'b00, 1);
    add(0, 0, 6'h00, 32'h0,        32'h0,       2'b00, 0);
    add(0, 0, 6'h00, 32'h0,        32'h0,       2'b00, 0);
    add(1, 0, 6'h03, 32'h1,        32'h0,       2'b01, 0);  // W1C vs match
    add(0, 1, 6'h03, 32'h0,        32'h3,       2'b01, 1);
    add(1, 0, 6'h00, 32'h0,        32'h3,       2'b00, 1);
    add(1, 0, 6'h03, 32'h1,        32'h3,       2'b00, 0);
    add(0, 1, 6'h10, 32'h0,        32'h0,       2'b00, 0);  // channel NUM_CH
    add(0, 1, 6'h01, 32'h0,        32'h4,       2'b00, 0);
    add(0, 1, 6'h05, 32'h0,        32'h0,       2'b00, 0);  // reserved
    add(1, 0, 6'h06, 32'hFFFF,     32'h0,       2'b00, 0);
    add(0, 1, 6'h06, 32'h0,        32'h0,       2'b00, 0);
    add(1, 0, 6'h10, 32'h5,        32'h0,       2'b00, 0);
    add(0, 1, 6'h10, 32'h0,        32'h0,       2'b00, 0);
    add(0, 1, 6'h01, 32'h0,        32'h4,       2'b00, 0);
    add(1, 0, 6'h08, 32'h30E,      32'h4,       2'b00, 0);
    add(0, 1, 6'h08, 32'h0,        ctrl_rb,     2'b00, 0);
    add(1, 0, 6'h08, 32'h0,        ctrl_rb,     2'b00, 0);

    foreach (tbl[i]) begin
      cycle(tbl[i].we, tbl[i].re, tbl[i].a, tbl[i].d);
      chk($sformatf("tbl%0d_rdata", i), bus_rdata, tbl[i].e_rd);
      chk($sformatf("tbl%0d_ch_irq", i), 32'(ch_irq), 32'(tbl[i].e_irq));
      chk($sformatf("tbl%0d_timer_int", i), 32'(timer_int), 32'(tbl[i].e_ti));
    end

    // Ch1 one-shot, CMP=2, prescale=3: pending after 12 cycles, then stops.
    cycle(1, 0, 6'h09, 32'd2);
    cycle(1, 0, 6'h08, 32'h307);
    wait_irq(1, 50, n);
    chk("oneshot_latency", 32'(n), 32'd12);
    cycle(0, 1, 6'h0B, 32'h0);
    chk("oneshot_stat", bus_rdata, 32'h1);
    cycle(0, 1, 6'h0A, 32'h0);
    chk("oneshot_cnt", bus_rdata, 32'h0);
    cycle(1, 0, 6'h0B, 32'h1);
    repeat (30) idle();
    chk("oneshot_no_repeat", 32'(ch_irq[1]), 32'h0);
    cycle(0, 1, 6'h0A, 32'h0);
    chk("oneshot_cnt_hold", bus_rdata, 32'h0);

    // Counter wrap: CNT=0xFFFFFFFE, CMP=1 -> pending on the 4th tick.
    cycle(1, 0, 6'h01, 32'd1);
    cycle(1, 0, 6'h02, 32'hFFFF_FFFE);
    cycle(1, 0, 6'h00, 32'h5);
    wait_irq(0, 20, n);
    chk("wrap_latency", 32'(n), 32'd4);

    // Asynchronous reset mid-count (cnt=3, pending set, mask on).
    cycle(1, 0, 6'h01, 32'd10);
    cycle(1, 0, 6'h02, 32'd0);
    repeat (3) idle();
    cycle(0, 1, 6'h02, 32'h0);
    chk("pre_reset_cnt", bus_rdata, 32'd3);
    #2 reset = 1;
    #1;
    chk("async_reset_rdata", bus_rdata, 32'h0);
    chk("async_reset_ch_irq", 32'(ch_irq), 32'h0);
    chk("async_reset_timer_int", 32'(timer_int), 32'h0);
    model_reset();
    @(negedge clk) reset = 0;
    cycle(0, 1, 6'h02, 32'h0);
    chk("post_reset_cnt", bus_rdata, 32'h0);
    cycle(0, 1, 6'h00, 32'h0);
    chk("post_reset_ctrl", bus_rdata, 32'h0);
    cycle(0, 1, 6'h10, 32'h0);
    chk("post_reset_ch_oob", bus_rdata, 32'h0);

`ifdef TIMER_CASCADE_EN
    // Ch0 CMP=1, ch1 cascaded CMP=2 -> ch1 pending 6 cycles after ch0 starts.
    cycle(1, 0, 6'h09, 32'd2);
    cycle(1, 0, 6'h01, 32'd1);
    cycle(1, 0, 6'h08, 32'hD);
    cycle(1, 0, 6'h00, 32'h1);
    wait_irq(1, 30, n);
    chk("cascade_latency", 32'(n), 32'd6);
`endif

    // Random bus traffic against the model.
    reset = 1;
    #3;
    model_reset();
    @(negedge clk) reset = 0;
    for (int t = 0; t < 2000; t++) begin
      ch = $urandom_range(0, 2);
      rg = $urandom_range(0, 4);
      d  = $urandom;
      case (rg)
        0: d = (32'($urandom_range(0, 3)) << 8) | (d & 32'hF);
        1: d = 32'($urandom_range(0, 7));
        2: d = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 7))
                                            : 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
        default: ;
      endcase
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
            {3'(ch), 3'(rg)}, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu_timer_multi.md
Name: cpu_timer_multi

Overview:
- Parametrised multi-channel timer for the 5-stage pipeline CPU; replaces the single free-running periodic timer.
- Each channel has a programmable compare value, a prescaler, a periodic or one-shot mode, and an enable.
- Each channel's interrupt is a sticky pending flag that stays set until software clears it.
- Registers sit behind a simple word-addressed bus with single-cycle write and registered read; the OR of the unmasked pending flags drives the CPU external interrupt line.

Parameters:
- NUM_CH, 2, number of timer channels (1..4).
- CNT_W, 32, counter and compare width in bits (8..32).
- PRE_W, 8, prescaler field width in bits.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- bus_we  in  1  write strobe, valid for one cycle
- bus_re  in  1  read strobe
- bus_addr  in  6  word address: bits[5:3] = channel, bits[2:0] = register
- bus_wdata  in  32  write data
- bus_rdata  out  32  read data, valid one cycle after bus_re
- ch_irq  out  NUM_CH  per-channel pending AND mask
- timer_int  out  1  OR of ch_irq, registered

Behaviour:
- Per-channel register map (bits[2:0]):
  - 0 CTRL: [0] en, [1] oneshot, [2] irq_mask_en, [PRE_W+7:8] prescale.
  - 1 CMP: compare value.
  - 2 CNT: current count; readable and writable.
  - 3 STAT: [0] pending (write-1-to-clear), [1] running (read-only).
  - 4–7: reserved; reads return 0, writes are ignored.
- Channel index >= NUM_CH: reads return 0, writes are ignored.
- Reset: every register is 0, so all channels are disabled. bus_rdata, ch_irq and timer_int are all 0.
- Prescaler:
  - pre_cnt counts 0..prescale. A tick is issued on the cycle pre_cnt == prescale, and pre_cnt then wraps to 0.
  - prescale = 0 gives a tick every cycle.
- Counter on each tick while en = 1:
  - If cnt == CMP: set pending and cnt <= 0.
    - Oneshot: en also clears in the same cycle.
    - Periodic: the counter keeps running.
  - Otherwise: cnt <= cnt + 1, wrapping modulo 2^CNT_W.
- Period is (CMP+1)*(prescale+1) cycles.
- CMP = 0: pending sets on every tick.
- en = 0: cnt and pre_cnt hold their values.
- Writing CTRL with en transitioning 0→1 resets pre_cnt to 0. It does not reset cnt.
- Writing CNT or CMP while running takes effect on the next cycle. If the new CMP is below cnt, the counter wraps through 2^CNT_W before matching.
- Simultaneous events:
  - A bus write to CNT takes priority over a counter update in the same cycle.
  - A hardware pending-set in the same cycle as a W1C clear leaves pending = 1 (set wins).
- ch_irq[i] = pending[i] & irq_mask_en[i], combinational.
- timer_int = |ch_irq, registered: a 1-cycle delay after pending sets.
- Read latency is 1 cycle. bus_rdata holds its last value when bus_re = 0.
- Reset is asynchronous at any time: it returns all channels to their reset state immediately.

Optional Feature:
- Macro TIMER_CASCADE_EN.
- Defined:
  - CTRL[3] becomes cascade.
  - When cascade = 1 on channel i > 0, the channel's tick source is the compare match of channel i-1 instead of its own prescaler.
  - This gives a 2*CNT_W effective period.
  - CTRL[3] on channel 0 is ignored.
- Undefined: CTRL[3] reads 0 and writes are ignored; every channel uses its own prescaler.

Decomposition:
- Shared package (in def.v):
  - Register offset defines TMR_CTRL, TMR_CMP, TMR_CNT, TMR_STAT.
  - CTRL bit-position defines.
  - Default NUM_CH.
- Sub-module timer_channel: prescaler, counter, compare, pending and mode logic for one channel, instantiated NUM_CH times.
- The top level holds the address decode, the read mux and the timer_int register.

Test Plan:
- Ch0, CMP=4, prescale=0, periodic, mask on → pending sets every 5 cycles. timer_int rises 1 cycle after pending; W1C to STAT clears it.
- Ch1, CMP=2, prescale=3, oneshot → pending sets after 12 cycles, en reads 0, and cnt stays at 0 with no further pending.
- W1C clear in the same cycle as a compare match → pending remains 1.
- CNT=0xFFFFFFFE with CMP=1 → cnt wraps to 0 and pending sets on the 4th tick.
- Reset asserted mid-count (cnt=3) → all reads return 0 the next cycle and timer_int = 0. Reads of channel index NUM_CH return 0.
- With TIMER_CASCADE_EN: ch0 CMP=1, ch1 cascade with CMP=2 → ch1 pending after 6 cycles.
